// File: rtl/byte_unpacker_if.sv
// Word-in / byte-out bundle between the 32-bit flop stage, byte_unpacker and the byte consumer.
// Latency: none (wires only).
// Backpressure: ready_out throttles bytes only; the word side has no backpressure and reports fill/overflow instead.
interface byte_unpacker_if #(
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic          valid_in;
  logic [31:0]   data_in;
  logic          ready_out;
  logic          valid_out;
  logic [7:0]    data_out;
  logic          almost_full;
  logic          overflow_err;
  logic [CW-1:0] fifo_count;

  // Producer/consumer side: drives words and byte-ready, observes bytes and status.
  modport master (
    output valid_in, data_in, ready_out,
    input  valid_out, data_out, almost_full, overflow_err, fifo_count
  );

  // Unpacker side.
  modport slave (
    input  valid_in, data_in, ready_out,
    output valid_out, data_out, almost_full, overflow_err, fifo_count
  );
endinterface

// File: rtl/byte_unpacker.sv
// Buffers 32-bit words in a DEPTH-entry FIFO and streams them out as bytes over ready/valid.
// Latency: word sampled at edge N -> byte 0 registered at N+1, then one byte per accepted cycle.
// Backpressure: ready_out=0 freezes the byte output; full FIFO drops new words and sets sticky overflow_err.
module byte_unpacker #(
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 3,
  parameter int MSB_FIRST = 1
) (
  input  logic           clk_2f,
  input  logic           reset_L,
  byte_unpacker_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);

  typedef enum logic {IDLE, SHIFT} state_t;

  // FIFO storage and bookkeeping
  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          af_q;
  logic          ovf_q;
  logic [31:0]   head;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  // Unpacker state
  state_t        state_q;
  state_t        state_d;
  logic [1:0]    idx_q;
  logic [1:0]    idx_d;
  logic [31:0]   word_q;
  logic [31:0]   word_d;
  logic          vld_q;
  logic          vld_d;
  logic [7:0]    dat_q;
  logic [7:0]    dat_d;
  logic          accept;

  // Byte i of a word in emission order; MSB-first maps index 0 to bits [31:24].
  function automatic logic [7:0] pick(input logic [31:0] w, input logic [1:0] i);
    logic [1:0] k;
    k = (MSB_FIRST != 0) ? ~i : i;
    case (k)
      2'd0:    pick = w[7:0];
      2'd1:    pick = w[15:8];
      2'd2:    pick = w[23:16];
      default: pick = w[31:24];
    endcase
  endfunction

  assign head       = mem[rd_ptr];
  assign fifo_empty = (count_q == '0);
  assign accept     = vld_q & bus.ready_out;

  // A pop in the same cycle frees a slot, so a full FIFO can still take a word while the unpacker loads.
  assign push = bus.valid_in & ((count_q < DEPTH_C) | pop);

  // Occupancy after this edge; status flags are registered from it so they move with the pointers.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Unpacker next state: load a word from IDLE or chain directly into the next word after byte 3.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    vld_d   = vld_q;
    dat_d   = dat_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          word_d  = head;
          idx_d   = 2'd0;
          dat_d   = pick(head, 2'd0);
          vld_d   = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (accept) begin
          if (idx_q != 2'd3) begin
            idx_d = idx_q + 2'd1;
            dat_d = pick(word_q, idx_q + 2'd1);
          end else if (!fifo_empty) begin
            // No bubble between words: valid_out stays high.
            pop    = 1'b1;
            word_d = head;
            idx_d  = 2'd0;
            dat_d  = pick(head, 2'd0);
          end else begin
            // Last byte gone and nothing queued; data_out keeps its last value.
            vld_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO write port; contents need no reset since the count gates every read.
  always_ff @(posedge clk_2f) begin
    if (push) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  // FIFO pointers, occupancy, almost_full and the sticky overflow flag.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_d;
      af_q    <= (count_d >= AF_C);
      if (bus.valid_in && !push) ovf_q <= 1'b1;
    end
  end

  // Unpacker registers; reset discards any partially emitted word.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      word_q  <= '0;
      vld_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
    end
  end

  assign bus.valid_out    = vld_q;
  assign bus.data_out     = dat_q;
  assign bus.almost_full  = af_q;
  assign bus.overflow_err = ovf_q;
  assign bus.fifo_count   = count_q;

  // Occupancy can never exceed the storage.
  a_count_bound: assert property (@(posedge clk_2f) disable iff (!reset_L)
    count_q <= DEPTH_C);

  // A stalled byte must stay put until it is taken.
  a_hold_stall: assert property (@(posedge clk_2f) disable iff (!reset_L)
    (vld_q && !bus.ready_out) |=> (vld_q && $stable(dat_q)));

  // Overflow only clears through reset.
  a_ovf_sticky: assert property (@(posedge clk_2f) disable iff (!reset_L)
    ovf_q |=> ovf_q);
endmodule

// File: tb/tb_byte_unpacker.sv
// Scoreboard bench for byte_unpacker: MSB-first and LSB-first instances driven with identical stimulus.
// Latency: checks word-to-byte timing, back-to-back chaining, overflow and async reset.
// Backpressure: exercises ready_out stalls and FIFO overflow with ready_out held low.
module tb_byte_unpacker;
  logic clk_2f;
  logic reset_L;

  byte_unpacker_if #(.DEPTH(4)) ia ();
  byte_unpacker_if #(.DEPTH(4)) ib ();

  byte_unpacker #(.DEPTH(4), .AF_THRESH(3), .MSB_FIRST(1)) dut_a (
    .clk_2f (clk_2f),
    .reset_L(reset_L),
    .bus    (ia)
  );

  byte_unpacker #(.DEPTH(4), .AF_THRESH(3), .MSB_FIRST(0)) dut_b (
    .clk_2f (clk_2f),
    .reset_L(reset_L),
    .bus    (ib)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_bytes_a = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  initial clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [31:0] d, input logic r);
    ia.valid_in  = v;
    ia.data_in   = d;
    ia.ready_out = r;
    ib.valid_in  = v;
    ib.data_in   = d;
    ib.ready_out = r;
  endtask

  // Present a word for the next edge and queue the bytes each instance must emit.
  task automatic drive_word(input logic [31:0] w, input logic r);
    set_in(1'b1, w, r);
    qa.push_back(w[31:24]);
    qa.push_back(w[23:16]);
    qa.push_back(w[15:8]);
    qa.push_back(w[7:0]);
    qb.push_back(w[7:0]);
    qb.push_back(w[15:8]);
    qb.push_back(w[23:16]);
    qb.push_back(w[31:24]);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (qa.size() == 0 && qb.size() == 0 && !ia.valid_out && !ib.valid_out) break;
      @(posedge clk_2f);
      #1;
    end
    check_val({tag, "_qa_left"}, qa.size(), 0);
    check_val({tag, "_qb_left"}, qb.size(), 0);
  endtask

  // Compare each byte on the cycle it is handed over (valid && ready at the coming edge).
  always @(negedge clk_2f) begin
    if (reset_L) begin
      if (ia.valid_out && ia.ready_out) begin
        n_bytes_a++;
        if (qa.size() == 0) check_val("a_spurious_byte", ia.valid_out, 0);
        else                check_val("a_byte", ia.data_out, qa.pop_front());
      end
      if (ib.valid_out && ib.ready_out) begin
        if (qb.size() == 0) check_val("b_spurious_byte", ib.valid_out, 0);
        else                check_val("b_byte", ib.data_out, qb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int vcyc;
    int rises;
    int maxc;
    int bytes0;
    logic prev;
    logic found;

    set_in(1'b0, 32'h0, 1'b1);
    reset_L = 1'b1;
    #1 reset_L = 1'b0;
    #1;
    check_val("rst_valid_out", ia.valid_out, 0);
    check_val("rst_data_out", ia.data_out, 0);
    check_val("rst_fifo_count", ia.fifo_count, 0);
    check_val("rst_almost_full", ia.almost_full, 0);
    check_val("rst_overflow", ia.overflow_err, 0);
    @(posedge clk_2f);
    @(posedge clk_2f);
    #3 reset_L = 1'b1;
    @(posedge clk_2f);
    #1;

    // Single word: timing of count, first byte and valid window.
    drive_word(32'hA1B2C3D4, 1'b1);
    @(posedge clk_2f); #1;
    set_in(1'b0, 32'h0, 1'b1);
    check_val("single_cnt_n", ia.fifo_count, 1);
    check_val("single_vld_n", ia.valid_out, 0);
    @(posedge clk_2f); #1;
    check_val("single_vld_n1", ia.valid_out, 1);
    check_val("single_byte0_msb", ia.data_out, 8'hA1);
    check_val("single_byte0_lsb", ib.data_out, 8'hD4);
    check_val("single_cnt_n1", ia.fifo_count, 0);
    for (int k = 2; k <= 5; k++) begin
      @(posedge clk_2f); #1;
      check_val("single_vld_window", ia.valid_out, (k <= 4) ? 1 : 0);
    end
    check_val("single_data_hold", ia.data_out, 8'hD4);
    drain("single");

    // Back-to-back words four cycles apart must chain without a gap.
    vcyc = 0; rises = 0; maxc = 0; prev = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (c == 0)      drive_word(32'h01020304, 1'b1);
      else if (c == 4) drive_word(32'h05060708, 1'b1);
      else             set_in(1'b0, 32'h0, 1'b1);
      @(posedge clk_2f); #1;
      if (ia.valid_out) vcyc++;
      if (ia.valid_out && !prev) rises++;
      prev = ia.valid_out;
      if (int'(ia.fifo_count) > maxc) maxc = int'(ia.fifo_count);
    end
    set_in(1'b0, 32'h0, 1'b1);
    check_val("b2b_valid_cycles", vcyc, 8);
    check_val("b2b_valid_rises", rises, 1);
    check_val("b2b_max_count", maxc, 1);
    drain("b2b");

    // Backpressure: hold byte 0 for three cycles.
    drive_word(32'hDEADBEEF, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk_2f); #1;
      set_in(1'b0, 32'h0, 1'b1);
      if (ia.valid_out) found = 1'b1;
    end
    check_val("bp_byte0_seen", ia.valid_out, 1);
    set_in(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_2f); #1;
      check_val("bp_hold_data", ia.data_out, 8'hDE);
      check_val("bp_hold_valid", ia.valid_out, 1);
    end
    set_in(1'b0, 32'h0, 1'b1);
    drain("bp");

    // Overflow: six words with the consumer stalled; the sixth is lost.
    set_in(1'b0, 32'h0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) drive_word(32'h11111111 * i, 1'b0);
      else        set_in(1'b1, 32'h11111111 * i, 1'b0);
      @(posedge clk_2f); #1;
      if (i == 3) begin
        check_val("ovf_cnt_w3", ia.fifo_count, 2);
        check_val("ovf_af_below", ia.almost_full, 0);
      end
      if (i == 4) check_val("ovf_af_at_thresh", ia.almost_full, 1);
      if (i == 5) begin
        check_val("ovf_cnt_full", ia.fifo_count, 4);
        check_val("ovf_err_not_yet", ia.overflow_err, 0);
      end
    end
    set_in(1'b0, 32'h0, 1'b0);
    check_val("ovf_cnt_after_drop", ia.fifo_count, 4);
    check_val("ovf_af_full", ia.almost_full, 1);
    check_val("ovf_err_set", ia.overflow_err, 1);
    @(posedge clk_2f); #1;
    check_val("ovf_err_held", ia.overflow_err, 1);
    bytes0 = n_bytes_a;
    set_in(1'b0, 32'h0, 1'b1);
    drain("ovf");
    check_val("ovf_byte_total", n_bytes_a - bytes0, 20);
    check_val("ovf_err_sticky", ia.overflow_err, 1);
    check_val("ovf_af_cleared", ia.almost_full, 0);

    // Async reset while byte 1 of 0xCAFEF00D is out and two words are queued.
    drive_word(32'hCAFEF00D, 1'b1);
    @(posedge clk_2f); #1;
    drive_word(32'h12345678, 1'b1);
    @(posedge clk_2f); #1;
    drive_word(32'h9ABCDEF0, 1'b1);
    @(posedge clk_2f); #1;
    set_in(1'b0, 32'h0, 1'b1);
    check_val("mid_pre_data", ia.data_out, 8'hFE);
    check_val("mid_pre_count", ia.fifo_count, 2);
    #2 reset_L = 1'b0;
    #1;
    check_val("mid_rst_valid", ia.valid_out, 0);
    check_val("mid_rst_data", ia.data_out, 0);
    check_val("mid_rst_count", ia.fifo_count, 0);
    check_val("mid_rst_overflow", ia.overflow_err, 0);
    qa.delete();
    qb.delete();
    @(posedge clk_2f);
    @(posedge clk_2f);
    #3 reset_L = 1'b1;
    vcyc = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_2f); #1;
      if (ia.valid_out || ib.valid_out) vcyc++;
    end
    check_val("mid_post_idle", vcyc, 0);

    // Recovery after reset.
    drive_word(32'hA1B2C3D4, 1'b1);
    @(posedge clk_2f); #1;
    set_in(1'b0, 32'h0, 1'b1);
    drain("recover");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/byte_unpacker.md
Name: byte_unpacker

Overview:
- Downstream stage of the 32-bit registered valid/data flop stage in the clk_2f domain.
- Buffers incoming 32-bit words in a small FIFO and emits them as a stream of 8-bit bytes.
- Emits one byte per accepted cycle, with a ready/valid handshake towards the next stage.
- The upstream stage has no backpressure, so this block reports fill level and a sticky overflow flag.

Parameters:
- DEPTH, 4, FIFO depth in 32-bit words; must be a power of 2 and ≥2.
- AF_THRESH, 3, almost_full asserts when fifo_count ≥ AF_THRESH.
- MSB_FIRST, 1, 1: byte order [31:24],[23:16],[15:8],[7:0]; 0: reverse order.

Ports:
- clk_2f  in  1  single clock; all logic on posedge.
- reset_L  in  1  asynchronous, active-low reset.
- valid_in  in  1  data_in holds a word this cycle.
- data_in  in  32  input word.
- ready_out  in  1  downstream can take a byte this cycle.
- valid_out  out  1  data_out holds a valid byte.
- data_out  out  8  output byte, registered.
- almost_full  out  1  fifo_count ≥ AF_THRESH.
- overflow_err  out  1  sticky: a word was dropped.
- fifo_count  out  $clog2(DEPTH)+1  words currently stored in the FIFO, excluding the word being unpacked.

Behaviour:
- Reset (reset_L=0, async):
  - valid_out=0, data_out=0, almost_full=0, overflow_err=0, fifo_count=0.
  - FIFO pointers cleared, state=IDLE, byte index=0.
  - Reset mid-word discards the partial word and all buffered words immediately; no byte from before reset appears after release.
- FIFO write:
  - On a posedge with valid_in=1, the word is written if fifo_count<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped and overflow_err sets to 1; it stays 1 until reset.
- FIFO pop: happens when the unpacker loads a new word. A simultaneous push and pop leaves fifo_count unchanged.
- Unpacker FSM: states IDLE, SHIFT; byte index idx runs 0..3.
  - IDLE: if fifo_count>0, pop the head word into the shift register, drive byte 0 on data_out, set valid_out=1, go to SHIFT with idx=0.
  - SHIFT, byte accepted (valid_out && ready_out at posedge), idx<3: idx+1, drive the next byte.
  - SHIFT, byte accepted, idx==3, FIFO non-empty: pop the next word and drive its byte 0 in the same edge. There is no bubble; valid_out stays 1.
  - SHIFT, byte accepted, idx==3, FIFO empty: valid_out=0, go to IDLE. data_out holds its last value.
  - SHIFT with ready_out=0: data_out, valid_out and idx hold stable (no drop, no duplicate).
- Latency:
  - A word sampled at edge N, with the FIFO and unpacker empty, gives fifo_count=1 after edge N.
  - Byte 0 is valid after edge N+1, and fifo_count returns to 0 at that edge.
  - With ready_out=1 throughout, bytes 1..3 follow at N+2..N+4.
- Throughput: sustained 1 word per 4 cycles. Upstream rates above that eventually fill the FIFO and set overflow_err.
- almost_full and fifo_count are registered and updated on the same edge as the FIFO pointers.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; fifo_count carries the full/empty distinction.
- valid_in=0 cycles: no write; data_in is ignored.

Test Plan:
- Single word, MSB_FIRST=1: reset, then valid_in=1 for one cycle with data_in=0xA1B2C3D4, ready_out=1.
  - Required: valid_out high for exactly 4 cycles starting 2 edges after the sample.
  - Required: data_out = 0xA1, 0xB2, 0xC3, 0xD4, then valid_out=0.
- Back-to-back words: 0x01020304 then, 4 cycles later, 0x05060708, ready_out=1.
  - Required: 8 consecutive bytes 01..08 with no valid_out gap.
  - Required: fifo_count never exceeds 1.
- Backpressure: word 0xDEADBEEF, ready_out=0 for 3 cycles after byte 0 appears.
  - Required: data_out stays 0xDE and valid_out stays 1 for those cycles.
  - Required: the remaining bytes 0xAD, 0xBE, 0xEF follow with no duplicates once ready_out=1.
- Overflow: ready_out=0, valid_in=1 for 6 consecutive cycles with words 0x11111111..0x66666666.
  - Required: word 1 sits in the unpacker; words 2..5 fill the FIFO, fifo_count reaches 4 and almost_full=1.
  - Required: word 6 is dropped and overflow_err=1 stays set.
  - Required: after ready_out=1, exactly 20 bytes (words 1..5) are emitted.
- Reset mid-operation: assert reset_L=0 asynchronously between edges while the 2nd byte of 0xCAFEF00D is on data_out with 2 words buffered.
  - Required: valid_out=0, data_out=0 and fifo_count=0 immediately.
  - Required: no byte is emitted after release until new input arrives.
- MSB_FIRST=0: word 0xA1B2C3D4 -> required bytes 0xD4, 0xC3, 0xB2, 0xA1.
